// File: rtl/pi_display_pkg.sv
// Shared constants and state type for the pi display path.
// Fixed-point layout: 4 integer bits above NFRAC fractional bits.
package pi_display_pkg;

  localparam int NBITS_PI = 64;
  localparam int NFRAC    = 60;
  localparam int NDIGITS  = 15;

  typedef enum logic {
    IDLE,
    CONV
  } conv_state_t;

endpackage

// File: rtl/pi_bcd_converter_if.sv
// Snapshot/result bundle between the pi accumulator side
// and the BCD converter.
interface pi_bcd_converter_if
  import pi_display_pkg::*;
();

  logic [NBITS_PI-1:0] pi_in;
  logic                start;
  logic                busy;
  logic                done;
  logic [NBITS_PI-1:0] bcd_out;
  logic                ovf;

  modport master (
    output pi_in,
    output start,
    input  busy,
    input  done,
    input  bcd_out,
    input  ovf
  );

  modport slave (
    input  pi_in,
    input  start,
    output busy,
    output done,
    output bcd_out,
    output ovf
  );

endinterface

// File: rtl/frac_times10.sv
// One decimal digit step: fraction x10, integer part out as digit.
// frac < 1 means the digit is always 0..9.
module frac_times10
  import pi_display_pkg::*;
(
  input  logic [NFRAC-1:0] frac_i,
  output logic [3:0]       digit_o,
  output logic [NFRAC-1:0] frac_o
);

  logic [NBITS_PI-1:0] f;
  logic [NBITS_PI-1:0] p;

  assign f = {{(NBITS_PI-NFRAC){1'b0}}, frac_i};

  always_comb begin
    p       = (f << 3) + (f << 1);
    digit_o = p[NBITS_PI-1:NFRAC];
    frac_o  = p[NFRAC-1:0];
  end

endmodule

// File: rtl/pi_bcd_converter.sv
// Snapshots the fixed-point pi value and emits 16 packed BCD
// digits, one fractional digit per cycle, into a held result.
module pi_bcd_converter
  import pi_display_pkg::*;
(
  input  logic               clk_2,
  input  logic               reset,
  pi_bcd_converter_if.slave  bus
);

  conv_state_t         state_q;
  logic [NFRAC-1:0]    frac_q;
  logic [NFRAC-1:0]    frac_nx;
  logic [3:0]          intd_q;
  logic [3:0]          cnt_q;
  logic [3:0]          digit;
  logic [NBITS_PI-1:0] sh_q;
  logic [NBITS_PI-1:0] sh_d;
  logic [NBITS_PI-1:0] bcd_q;
  logic                busy_q;
  logic                done_q;
  logic                ovf_q;

  frac_times10 u_mul (
    .frac_i  (frac_q),
    .digit_o (digit),
    .frac_o  (frac_nx)
  );

  assign sh_d = {sh_q[NBITS_PI-5:0], digit};

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      frac_q  <= '0;
      intd_q  <= '0;
      cnt_q   <= '0;
      sh_q    <= '0;
      bcd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            frac_q  <= bus.pi_in[NFRAC-1:0];
            intd_q  <= bus.pi_in[NBITS_PI-1:NFRAC];
            cnt_q   <= '0;
            sh_q    <= {{(NBITS_PI-4){1'b0}},
                        bus.pi_in[NBITS_PI-1:NFRAC]};
            busy_q  <= 1'b1;
            state_q <= CONV;
          end
        end
        CONV: begin
          frac_q <= frac_nx;
          sh_q   <= sh_d;
          cnt_q  <= cnt_q + 4'd1;
          // Last digit lands straight in the result register.
          if (cnt_q == 4'(NDIGITS-1)) begin
            bcd_q   <= sh_d;
            ovf_q   <= (intd_q > 4'd9);
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.bcd_out = bcd_q;
  assign bus.ovf     = ovf_q;

endmodule
